// File: rtl/safety_monitor_multi_pkg.sv
// Shared types and helpers for the multi-channel motor-current safety monitor.
// Offset-binary codes: mid-scale is zero current.
package safety_pkg;

  typedef enum logic [1:0] {
    MON  = 2'd0,
    OVER = 2'd1,
    TRIP = 2'd2
  } chan_state_t;

  localparam int unsigned CUR_W_DEF = 16;
  localparam logic [CUR_W_DEF-1:0] MID = {1'b1, {(CUR_W_DEF-1){1'b0}}};

  function automatic logic [31:0] mid_code(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // Distance of an offset-binary code from mid-scale.
  function automatic logic [31:0] mag(input logic [31:0] code, input logic [31:0] mid);
    return (code >= mid) ? (code - mid) : (mid - code);
  endfunction

endpackage

// File: rtl/safety_monitor_multi_if.sv
// Register/converter-side signal bundle for safety_monitor_multi.
// master = board registers and ADC/DAC side, slave = the monitor.
interface safety_monitor_multi_if
  import safety_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CUR_W  = CUR_W_DEF,
  parameter int unsigned TCNT_W = 8
) ();

  logic                     cur_valid;
  logic [NUM_CH*CUR_W-1:0]  cur_fb;
  logic [NUM_CH*CUR_W-1:0]  cur_cmd;
  logic                     cmd_wen;
  logic [NUM_CH-1:0]        ch_enable;
  logic                     clr_wen;
  logic [NUM_CH-1:0]        clr_mask;
  logic [NUM_CH-1:0]        amp_disable;
  logic                     trip_pulse;
  logic [NUM_CH*TCNT_W-1:0] trip_count;

  modport master (
    output cur_valid, cur_fb, cur_cmd, cmd_wen, ch_enable, clr_wen, clr_mask,
    input  amp_disable, trip_pulse, trip_count
  );

  modport slave (
    input  cur_valid, cur_fb, cur_cmd, cmd_wen, ch_enable, clr_wen, clr_mask,
    output amp_disable, trip_pulse, trip_count
  );

endinterface

// File: rtl/safety_monitor_multi_chan.sv
// One monitored channel: magnitude compare, one register stage, then the
// MON/OVER/TRIP persistence FSM with a saturating trip counter.
module safety_chan
  import safety_pkg::*;
#(
  parameter int unsigned CUR_W   = CUR_W_DEF,
  parameter int unsigned MARGIN  = 32'h0200,
  parameter int unsigned PERSIST = 8,
  parameter int unsigned TCNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_i,
  input  logic [CUR_W-1:0]  fb_i,
  input  logic [CUR_W-1:0]  cmd_i,
  input  logic              blank_i,
  input  logic              enable_i,
  input  logic              clr_i,
  output logic              amp_disable_o,
  output logic              trip_pulse_o,
  output logic [TCNT_W-1:0] trip_count_o
);

  localparam int unsigned LIM_W  = CUR_W + 2;
  localparam int unsigned PCNT_W = (PERSIST > 1) ? $clog2(PERSIST) : 1;
  localparam logic [31:0] MID_C  = mid_code(CUR_W);

  logic [CUR_W-1:0]  fb_mag;
  logic [CUR_W-1:0]  cmd_mag;
  logic [LIM_W-1:0]  limit;

  logic              valid_q, valid_d;
  logic              over_q,  over_d;
  logic              block_q, block_d;
  chan_state_t       state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q,  pcnt_d;
  logic              pulse_q, pulse_d;
  logic [TCNT_W-1:0] tcnt_q,  tcnt_d;
  logic              enter_trip;

  // Stage 1: sample, over-limit flag and suppression are registered together
  // so the FSM always judges a sample with the conditions of its own cycle.
  always_comb begin
    fb_mag  = CUR_W'(mag(32'(fb_i), MID_C));
    cmd_mag = CUR_W'(mag(32'(cmd_i), MID_C));
    limit   = (LIM_W'(cmd_mag) << 1) + LIM_W'(MARGIN);
    valid_d = sample_i;
    over_d  = LIM_W'(fb_mag) > limit;
    block_d = blank_i | ~enable_i;
  end

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    pulse_d    = 1'b0;
    tcnt_d     = tcnt_q;
    enter_trip = 1'b0;

    case (state_q)
      MON: begin
        pcnt_d = '0;
        if (valid_q && !block_q && over_q) begin
          if (PERSIST == 1) begin
            enter_trip = 1'b1;
          end else begin
            state_d = OVER;
            pcnt_d  = PCNT_W'(1);
          end
        end
      end
      OVER: begin
        if (block_q) begin
          state_d = MON;
          pcnt_d  = '0;
        end else if (valid_q) begin
          if (!over_q) begin
            state_d = MON;
            pcnt_d  = '0;
          end else if (pcnt_q == PCNT_W'(PERSIST - 1)) begin
            enter_trip = 1'b1;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
      end
      TRIP: begin
        pcnt_d = '0;
        if (clr_i) begin
          state_d = MON;
        end
      end
      default: begin
        state_d = MON;
        pcnt_d  = '0;
      end
    endcase

    // Clear only acts on a state already in TRIP, so a clear landing on the
    // entry cycle loses to the new trip.
    if (enter_trip) begin
      state_d = TRIP;
      pcnt_d  = '0;
      pulse_d = 1'b1;
      if (tcnt_q != '1) begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      over_q  <= 1'b0;
      block_q <= 1'b0;
      state_q <= MON;
      pcnt_q  <= '0;
      pulse_q <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      over_q  <= over_d;
      block_q <= block_d;
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      pulse_q <= pulse_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign amp_disable_o = (state_q == TRIP);
  assign trip_pulse_o  = pulse_q;
  assign trip_count_o  = tcnt_q;

endmodule

// File: rtl/safety_monitor_multi.sv
// N-channel motor-current safety monitor: shared post-command blanking timer
// plus one safety_chan per channel; trip pulses are merged into one strobe.
module safety_monitor_multi
  import safety_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CUR_W     = CUR_W_DEF,
  parameter int unsigned MARGIN    = 32'h0200,
  parameter int unsigned PERSIST   = 8,
  parameter int unsigned BLANK_CYC = 4096,
  parameter int unsigned TCNT_W    = 8
) (
  input  logic                   sysclk,
  input  logic                   reset,
  safety_monitor_multi_if.slave  bus
);

  localparam int unsigned BLANK_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

  logic [BLANK_W-1:0]       blank_q, blank_d;
  logic                     blank_now;
  logic [NUM_CH-1:0]        amp_w;
  logic [NUM_CH-1:0]        pulse_w;
  logic [NUM_CH*TCNT_W-1:0] tcnt_w;

  // A command write blanks its own cycle too, so a coincident sample is ignored.
  always_comb begin
    blank_d = blank_q;
    if (bus.cmd_wen) begin
      blank_d = BLANK_W'(BLANK_CYC);
    end else if (blank_q != '0) begin
      blank_d = blank_q - 1'b1;
    end
    blank_now = bus.cmd_wen | (blank_q != '0);
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    safety_chan #(
      .CUR_W   (CUR_W),
      .MARGIN  (MARGIN),
      .PERSIST (PERSIST),
      .TCNT_W  (TCNT_W)
    ) u_chan (
      .clk           (sysclk),
      .rst_n         (reset),
      .sample_i      (bus.cur_valid),
      .fb_i          (bus.cur_fb[g*CUR_W +: CUR_W]),
      .cmd_i         (bus.cur_cmd[g*CUR_W +: CUR_W]),
      .blank_i       (blank_now),
      .enable_i      (bus.ch_enable[g]),
      .clr_i         (bus.clr_wen & bus.clr_mask[g]),
      .amp_disable_o (amp_w[g]),
      .trip_pulse_o  (pulse_w[g]),
      .trip_count_o  (tcnt_w[g*TCNT_W +: TCNT_W])
    );
  end

  assign bus.amp_disable = amp_w;
  assign bus.trip_pulse  = |pulse_w;
  assign bus.trip_count  = tcnt_w;

endmodule
